hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller; produces the `stall` input consumed by the ID/EX pipeline register, plus front-end hold/flush and EX-stage forwarding selects.
- Keeps a shadow pipeline of destination-register/load tags for the EX, MEM and WB stages, advanced in lock-step with the datapath registers.
- Detects load-use hazards and taken-branch redirects, drives the forwarding muxes, and keeps stall/flush performance counters.

Parameters:
- OP_LOAD, 4'd5, `op_type` encoding that marks a load (data valid only at end of MEM).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID stage holds a real instruction.
- id_op_type  in  4  `op_type` of the ID instruction.
- id_rs_addr  in  5  ID source register 1 address.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_addr  in  5  ID source register 2 address.
- id_rt_used  in  1  ID instruction reads rt.
- id_wr_addr  in  5  ID destination register; 0 = no write.
- ex_rs_addr  in  5  `register_1_addr` currently in EX.
- ex_rt_addr  in  5  `register_2_addr` currently in EX.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- stall  out  1  to ID/EX register; loads a bubble next edge.
- hold_pc  out  1  PC keeps its value next edge.
- hold_if_id  out  1  IF/ID register keeps its value next edge.
- flush_if_id  out  1  IF/ID register loads a bubble next edge.
- fwd_a_sel  out  2  EX operand A source: 00 regfile/ID-EX, 01 MEM result, 10 WB result.
- fwd_b_sel  out  2  same encoding for operand B.
- stall_count  out  CNT_W  number of load-use stall cycles.
- flush_count  out  CNT_W  number of redirect cycles.

Behaviour:
- Shadow state: three slots ex, mem, wb, each holding {dest[4:0], is_load}.
- Every posedge: wb <= mem; mem <= ex; ex <= ({id_wr_addr, id_op_type==OP_LOAD} if id_valid and not stall, else {0,0}).
- dest==0 means no write. Register 0 never creates a hazard and is never forwarded.
- Load-use hazard (lu): id_valid and ex.is_load and ex.dest!=0 and ((id_rs_used and id_rs_addr==ex.dest) or (id_rt_used and id_rt_addr==ex.dest)).
- Hazard is checked against the ex slot only. A load in mem is resolved by WB forwarding; a load in wb is resolved by the register file.
- lu without redirect: stall=1, hold_pc=1, hold_if_id=1, flush_if_id=0.
  - Exactly one bubble is inserted; the next cycle the load sits in mem, lu drops, and the instruction proceeds.
- ex_redirect=1 (wins over lu): stall=1, flush_if_id=1, hold_pc=0, hold_if_id=0.
  - Both wrong-path instructions (ID and IF) are squashed; PC takes the redirect target.
- Neither event: all four control outputs 0.
- The four control outputs are combinational from the current inputs and shadow state; there is no extra latency.
- Forwarding, operand A (B identical using ex_rt_addr):
  - 01 if mem.dest!=0 and mem.dest==ex_rs_addr and !mem.is_load;
  - else 10 if wb.dest!=0 and wb.dest==ex_rs_addr;
  - else 00.
  - MEM takes priority over WB when both match. A load in mem is never forwarded from MEM.
- Counters:
  - stall_count increments on each posedge where lu=1 and ex_redirect=0.
  - flush_count increments on each posedge where ex_redirect=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset (asynchronous, any time, including mid-stall):
  - all slots become {0,0}; counters become 0;
  - stall/hold_pc/hold_if_id/flush_if_id and fwd selects evaluate to 0 while inputs are idle.
  - The first edge after deassertion behaves as a normal shift.
- id_valid=0: no hazard is raised, and a bubble enters the ex slot.

Test Plan:
- Load r5 (id_op_type=OP_LOAD, id_wr_addr=5), next cycle ID reads rs=5 → exactly one cycle with stall=hold_pc=hold_if_id=1; next cycle stall=0; when the consumer reaches EX (ex_rs_addr=5, load in wb) → fwd_a_sel=10; stall_count=1.
- ALU writes r3, then consumer reads r3 in rt → no stall; with producer in mem and ex_rt_addr=3 → fwd_b_sel=01. Same producer two instructions back → 10. Both mem and wb write r3 → 01.
- Load r0 followed by a reader of r0 → stall never asserted, fwd selects stay 00. Load r7 followed by reader with id_rs_used=0 and rs=7 → no stall.
- ex_redirect=1 in the same cycle as lu → stall=1, flush_if_id=1, hold_pc=0; flush_count increments and stall_count does not.
- Assert reset mid-stall (between edges) → outputs drop to 0 immediately and counters read 0. After release, a load → use sequence stalls exactly once again.
- Drive 2^CNT_W redirects with CNT_W overridden to 4 → flush_count wraps 15→0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB tag pipeline, load-use stall,
// redirect flush, EX-stage forwarding selects and stall/flush event counters.
module hazard_ctrl #(
  parameter logic [3:0] OP_LOAD = 4'd5,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [3:0]       id_op_type,
  input  logic [4:0]       id_rs_addr,
  input  logic             id_rs_used,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_rt_used,
  input  logic [4:0]       id_wr_addr,
  input  logic [4:0]       ex_rs_addr,
  input  logic [4:0]       ex_rt_addr,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             flush_if_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0] r_ex_dest, r_mem_dest, r_wb_dest;
  logic       r_ex_load, r_mem_load, r_wb_load;

  logic w_rs_hit, w_rt_hit, w_lu, w_stall;

  // Only a load still in EX needs a bubble; later stages are covered by forwarding/regfile.
  assign w_rs_hit = id_rs_used && (id_rs_addr == r_ex_dest);
  assign w_rt_hit = id_rt_used && (id_rt_addr == r_ex_dest);
  assign w_lu     = id_valid && r_ex_load && (r_ex_dest != 5'd0) && (w_rs_hit || w_rt_hit);
  assign w_stall  = w_lu || ex_redirect;

  assign stall       = w_stall;
  assign flush_if_id = ex_redirect;
  assign hold_pc     = w_lu && !ex_redirect;
  assign hold_if_id  = w_lu && !ex_redirect;

  always_comb begin
    fwd_a_sel = 2'b00;
    if ((r_mem_dest != 5'd0) && (r_mem_dest == ex_rs_addr) && !r_mem_load)
      fwd_a_sel = 2'b01;
    else if ((r_wb_dest != 5'd0) && (r_wb_dest == ex_rs_addr))
      fwd_a_sel = 2'b10;
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    if ((r_mem_dest != 5'd0) && (r_mem_dest == ex_rt_addr) && !r_mem_load)
      fwd_b_sel = 2'b01;
    else if ((r_wb_dest != 5'd0) && (r_wb_dest == ex_rt_addr))
      fwd_b_sel = 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_dest  <= 5'd0;
      r_ex_load  <= 1'b0;
      r_mem_dest <= 5'd0;
      r_mem_load <= 1'b0;
      r_wb_dest  <= 5'd0;
      r_wb_load  <= 1'b0;
    end else begin
      r_wb_dest  <= r_mem_dest;
      r_wb_load  <= r_mem_load;
      r_mem_dest <= r_ex_dest;
      r_mem_load <= r_ex_load;
      if (id_valid && !w_stall) begin
        r_ex_dest <= id_wr_addr;
        r_ex_load <= (id_op_type == OP_LOAD);
      end else begin
        r_ex_dest <= 5'd0;
        r_ex_load <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (w_lu && !ex_redirect) stall_count <= stall_count + CNT_ONE;
      if (ex_redirect)          flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_hazard_ctrl;

  logic       clk, reset;
  logic       id_valid, id_rs_used, id_rt_used, ex_redirect;
  logic [3:0] id_op_type;
  logic [4:0] id_rs_addr, id_rt_addr, id_wr_addr, ex_rs_addr, ex_rt_addr;
  logic       stall, hold_pc, hold_if_id, flush_if_id;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_count, flush_count;
  logic       s4_stall, s4_hold_pc, s4_hold_if_id, s4_flush_if_id;
  logic [1:0] s4_fwd_a, s4_fwd_b;
  logic [3:0] s4_stall_count, s4_flush_count;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op_type(id_op_type),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used), .id_rt_addr(id_rt_addr),
    .id_rt_used(id_rt_used), .id_wr_addr(id_wr_addr), .ex_rs_addr(ex_rs_addr),
    .ex_rt_addr(ex_rt_addr), .ex_redirect(ex_redirect), .stall(stall),
    .hold_pc(hold_pc), .hold_if_id(hold_if_id), .flush_if_id(flush_if_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op_type(id_op_type),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used), .id_rt_addr(id_rt_addr),
    .id_rt_used(id_rt_used), .id_wr_addr(id_wr_addr), .ex_rs_addr(ex_rs_addr),
    .ex_rt_addr(ex_rt_addr), .ex_redirect(ex_redirect), .stall(s4_stall),
    .hold_pc(s4_hold_pc), .hold_if_id(s4_hold_if_id), .flush_if_id(s4_flush_if_id),
    .fwd_a_sel(s4_fwd_a), .fwd_b_sel(s4_fwd_b),
    .stall_count(s4_stall_count), .flush_count(s4_flush_count)
  );

  typedef struct {
    string       name;
    logic [75:0] v;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_sc  = 0;
  logic [31:0] exp_fc  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", q.size());
    $fatal(1, "timeout");
  end

  // {stall, hold_pc, hold_if_id, flush, fwd_a, fwd_b, stall_count, flush_count, flush_count(4b)}
  always @(negedge clk) begin
    logic [75:0] act;
    exp_t        e;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = {stall, hold_pc, hold_if_id, flush_if_id, fwd_a_sel, fwd_b_sel,
             stall_count, flush_count, s4_flush_count};
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b fa=%b fb=%b sc=%0d fc=%0d fc4=%0d, want ctl=%b fa=%b fb=%b sc=%0d fc=%0d fc4=%0d",
                 e.name, act[75:72], act[71:70], act[69:68], act[67:36], act[35:4], act[3:0],
                 e.v[75:72], e.v[71:70], e.v[69:68], e.v[67:36], e.v[35:4], e.v[3:0]);
      end
    end
  end

  task automatic put(input string nm, input logic s, input logic hp, input logic hi,
                     input logic fl, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.name = nm;
    e.v    = {s, hp, hi, fl, fa, fb, exp_sc, exp_fc, exp_fc[3:0]};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    id_valid = 0; id_op_type = 0; id_rs_addr = 0; id_rs_used = 0;
    id_rt_addr = 0; id_rt_used = 0; id_wr_addr = 0;
    ex_rs_addr = 0; ex_rt_addr = 0; ex_redirect = 0;
  endtask

  task automatic id_in(input logic [3:0] op, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] wr);
    id_valid = 1; id_op_type = op; id_rs_addr = rs; id_rs_used = rsu;
    id_rt_addr = rt; id_rt_used = rtu; id_wr_addr = wr;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset = 1;
    id_valid = 0; id_op_type = 0; id_rs_addr = 0; id_rs_used = 0;
    id_rt_addr = 0; id_rt_used = 0; id_wr_addr = 0;
    ex_rs_addr = 0; ex_rt_addr = 0; ex_redirect = 0;
    put("reset_state", 0, 0, 0, 0, 2'b00, 2'b00);
    @(negedge clk); #1;
    reset = 0;

    // load r5 then use of r5 in rs
    tick(); id_in(4'd5, 5'd0, 0, 5'd0, 0, 5'd5);     put("lu_load_issue", 0, 0, 0, 0, 2'b00, 2'b00);
    tick(); id_in(4'd0, 5'd5, 1, 5'd0, 0, 5'd6);     put("lu_stall",      1, 1, 1, 0, 2'b00, 2'b00);
    tick(); exp_sc = 1;
    id_in(4'd0, 5'd5, 1, 5'd0, 0, 5'd6); ex_rs_addr = 5;
    put("lu_release_no_mem_load_fwd", 0, 0, 0, 0, 2'b00, 2'b00);
    tick(); ex_rs_addr = 5;                          put("lu_fwd_wb",     0, 0, 0, 0, 2'b10, 2'b00);
    idle(3);

    // ALU producer r3, consumer in rt
    tick(); id_in(4'd0, 5'd0, 0, 5'd0, 0, 5'd3);     put("alu_issue",     0, 0, 0, 0, 2'b00, 2'b00);
    tick(); id_in(4'd0, 5'd0, 0, 5'd3, 1, 5'd0);     put("alu_no_stall",  0, 0, 0, 0, 2'b00, 2'b00);
    tick(); ex_rt_addr = 3;                          put("fwd_b_mem",     0, 0, 0, 0, 2'b00, 2'b01);
    tick(); ex_rt_addr = 3;                          put("fwd_b_wb",      0, 0, 0, 0, 2'b00, 2'b10);
    tick(); id_in(4'd0, 5'd0, 0, 5'd0, 0, 5'd3);
    tick(); id_in(4'd0, 5'd0, 0, 5'd0, 0, 5'd3);
    tick();
    tick(); ex_rs_addr = 3; ex_rt_addr = 3;          put("fwd_mem_over_wb", 0, 0, 0, 0, 2'b01, 2'b01);
    idle(3);

    // r0 never hazards or forwards; unused rs never hazards
    tick(); id_in(4'd5, 5'd0, 0, 5'd0, 0, 5'd0);     put("r0_load",       0, 0, 0, 0, 2'b00, 2'b00);
    tick(); id_in(4'd0, 5'd0, 1, 5'd0, 1, 5'd0);     put("r0_reader",     0, 0, 0, 0, 2'b00, 2'b00);
    tick();                                          put("r0_no_fwd",     0, 0, 0, 0, 2'b00, 2'b00);
    tick(); id_in(4'd5, 5'd0, 0, 5'd0, 0, 5'd7);     put("r7_load",       0, 0, 0, 0, 2'b00, 2'b00);
    tick(); id_in(4'd0, 5'd7, 0, 5'd1, 1, 5'd2);     put("rs_unused",     0, 0, 0, 0, 2'b00, 2'b00);
    idle(3);

    // redirect coincident with load-use
    tick(); id_in(4'd5, 5'd0, 0, 5'd0, 0, 5'd9);     put("redir_load",    0, 0, 0, 0, 2'b00, 2'b00);
    tick(); id_in(4'd0, 5'd9, 1, 5'd0, 0, 5'd1); ex_redirect = 1;
    put("redir_wins", 1, 0, 0, 1, 2'b00, 2'b00);
    tick(); exp_fc = 1;
    id_in(4'd0, 5'd9, 1, 5'd0, 0, 5'd1);             put("redir_counts",  0, 0, 0, 0, 2'b00, 2'b00);
    idle(3);

    // reset in the middle of a stall
    tick(); id_in(4'd5, 5'd0, 0, 5'd0, 0, 5'd4);
    tick(); id_in(4'd0, 5'd0, 0, 5'd4, 1, 5'd8);     put("pre_rst_stall", 1, 1, 1, 0, 2'b00, 2'b00);
    @(negedge clk); #1;
    reset = 1;
    exp_sc = 0; exp_fc = 0;
    put("rst_mid_stall", 0, 0, 0, 0, 2'b00, 2'b00);
    @(negedge clk); #1;
    reset = 0;
    tick(); id_in(4'd5, 5'd0, 0, 5'd0, 0, 5'd4);     put("post_rst_load", 0, 0, 0, 0, 2'b00, 2'b00);
    tick(); id_in(4'd0, 5'd0, 0, 5'd4, 1, 5'd8);     put("post_rst_stall", 1, 1, 1, 0, 2'b00, 2'b00);
    tick(); exp_sc = 1;
    id_in(4'd0, 5'd0, 0, 5'd4, 1, 5'd8);             put("post_rst_once", 0, 0, 0, 0, 2'b00, 2'b00);

    // flush counter wrap on the 4-bit instance
    tick(); reset = 1; exp_sc = 0; exp_fc = 0;
    @(negedge clk); #1;
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      tick(); ex_redirect = 1; exp_fc = i;
      put("redir_run", 1, 0, 0, 1, 2'b00, 2'b00);
    end
    tick(); exp_fc = 16;                             put("flush_wrap",    0, 0, 0, 0, 2'b00, 2'b00);

    tick();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
